// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the decode stage and the iterative multiply/divide unit.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU plus MTHI/MTLO into HI/LO, one bit per cycle.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise DIV/DIVU are no-ops.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 neg_res_q, neg_res_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
`ifdef MULDIV_DIV_EN
  logic                 is_div_q, is_div_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 div0_q, div0_d;
  logic [WIDTH:0]       rem_tmp, div_diff;
  logic [2*WIDTH-1:0]   div_step;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
`endif

  logic                 signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag, mul_addend;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_step, prod_fix;

  // Signed ops work on magnitudes; op[0] set means the unsigned variant.
  assign signed_op = ~bus.op[0];
  assign a_neg     = signed_op & bus.rs_data[WIDTH-1];
  assign b_neg     = signed_op & bus.rt_data[WIDTH-1];
  assign a_mag     = a_neg ? -bus.rs_data : bus.rs_data;
  assign b_mag     = b_neg ? -bus.rt_data : bus.rt_data;

  // acc holds {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_addend = acc_q[0] ? b_q : '0;
  assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
  assign mul_step   = {mul_sum, acc_q[WIDTH-1:1]};
  assign prod_fix   = neg_res_q ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
  // acc holds {remainder, dividend/quotient}, shifted left each step.
  assign rem_tmp  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = rem_tmp - {1'b0, b_q};
  assign div_step = div_diff[WIDTH] ? {rem_tmp[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    neg_res_d = neg_res_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
`ifdef MULDIV_DIV_EN
    is_div_d  = is_div_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          case (bus.op)
`ifdef MULDIV_DIV_EN
            3'b000, 3'b001, 3'b010, 3'b011: begin
`else
            3'b000, 3'b001: begin
`endif
              acc_d     = {{WIDTH{1'b0}}, a_mag};
              b_d       = b_mag;
              neg_res_d = a_neg ^ b_neg;
              cnt_d     = '0;
              state_d   = StCalc;
`ifdef MULDIV_DIV_EN
              is_div_d  = bus.op[1];
              neg_rem_d = a_neg;
              div0_d    = (bus.rt_data == '0);
`endif
            end
            3'b100:  hi_d = bus.rs_data;
            3'b101:  lo_d = bus.rs_data;
            default: ;
          endcase
        end
      end
      StCalc: begin
        cnt_d = cnt_q + 1'b1;
`ifdef MULDIV_DIV_EN
        acc_d = is_div_q ? div_step : mul_step;
`else
        acc_d = mul_step;
`endif
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        {hi_d, lo_d} = prod_fix;
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = div0_q ? '1 : quo_fix;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      neg_res_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      neg_res_q <= neg_res_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
`ifdef MULDIV_DIV_EN
      is_div_q  <= is_div_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
`endif
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
